// File: rtl/bit_4serializer_pkg.sv
// bit_4serializer_pkg: FSM state encoding, default word width and beat-counter width helper
package bit_4serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/bit_4serializer_shift_stage.sv
// bit_4serializer_shift_stage: one sreg bit (clk, rst, load_i+d_i parallel load, shift_i+nb_i neighbour shift, q_o bit), load beats shift beats hold
module bit_4serializer_shift_stage (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic shift_i,
  input  logic d_i,
  input  logic nb_i,
  output logic q_o
);
  logic q_q, q_d;
  always_comb q_d = load_i ? d_i : shift_i ? nb_i : q_q;
  always_ff @(posedge clk) q_q <= rst ? 1'b0 : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/bit_4serializer.sv
// bit_4serializer: PISO with load handshake (load, D, in_ready) and serial valid/ready link (sout, sout_valid, sout_last, sout_ready)
module bit_4serializer
  import bit_4serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, nb;
  logic             beat, last, ld;
  always_comb begin
    last     = cnt_q == CW'(WIDTH - 1);
    beat     = state_q == SHIFT && sout_ready;
    in_ready = !rst && (state_q == IDLE || (beat && last));
    ld       = load && in_ready;
    state_d  = ld ? SHIFT : (beat && last) ? IDLE : state_q;
    cnt_d    = ld ? '0 : beat ? cnt_q + CW'(1) : cnt_q;
    nb       = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    bit_4serializer_shift_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .load_i (ld),
      .shift_i(beat),
      .d_i    (D[i]),
      .nb_i   (nb[i]),
      .q_o    (sreg_q[i])
    );
  end
  assign sout_valid = state_q == SHIFT;
  assign sout       = sout_valid && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign sout_last  = sout_valid && last;
endmodule

// File: tb/tb_bit_4serializer.sv
// tb_bit_4serializer: randomized and directed checks of both bit orders against a word/bit-index reference model
module tb_bit_4serializer;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, sout_ready = 1'b0;
  logic [3:0] D = 4'h0;
  logic ir0, s0, sv0, sl0, ir1, s1, sv1, sl1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bit_4serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .D(D), .in_ready(ir0),
    .sout(s0), .sout_valid(sv0), .sout_last(sl0), .sout_ready(sout_ready));
  bit_4serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .D(D), .in_ready(ir1),
    .sout(s1), .sout_valid(sv1), .sout_last(sl1), .sout_ready(sout_ready));

  // Reference: the word in flight and the index of the bit currently on the link.
  logic       m_busy = 1'b0;
  logic [3:0] m_word = 4'h0;
  logic [1:0] m_k = 2'd0;
  logic       m_rdy;
  assign m_rdy = !rst && (!m_busy || (m_k == 2'd3 && sout_ready));
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 2'd0;
      m_word <= 4'h0;
    end else if (load && m_rdy) begin
      m_busy <= 1'b1;
      m_word <= D;
      m_k    <= 2'd0;
    end else if (m_busy && sout_ready) begin
      m_busy <= m_k != 2'd3;
      m_k    <= m_k + 2'd1;
    end
  end

  function automatic logic [7:0] exp_v();
    logic lst;
    lst = m_busy && m_k == 2'd3;
    return {m_rdy, m_busy, m_busy & m_word[2'd3 - m_k], lst,
            m_rdy, m_busy, m_busy & m_word[m_k], lst};
  endfunction

  function automatic logic [7:0] obs();
    return {ir0, sv0, s0, sl0, ir1, sv1, s1, sl1};
  endfunction

  task automatic drive(input logic l, input logic [3:0] d, input logic r, input logic rs);
    @(negedge clk);
    load = l; D = d; sout_ready = r; rst = rs;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'hF, 1'b1, 1'b1);
      checks++;
      if ({sv0, ir0, sv1, ir1} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold cyc %0d: got %b want 0000", i, {sv0, ir0, sv1, ir1});
      end
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({ir0, s0, sv0} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: got %b want 100", {ir0, s0, sv0});
    end
    checks++;
    if (obs() !== exp_v()) begin
      failures++;
      $display("FAIL model_reset: got %b want %b", obs(), exp_v());
    end
  endtask

  task automatic test_single();
    logic [3:0] a = 4'h0, b = 4'h0, lm = 4'h0;
    drive(1'b1, 4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_single cyc %0d: got %b want %b", i, obs(), exp_v());
      end
      a = {a[2:0], s0}; b = {b[2:0], s1}; lm = {lm[2:0], sl0};
    end
    checks++;
    if (a !== 4'b1010) begin failures++; $display("FAIL single_msb: got %b want 1010", a); end
    checks++;
    if (b !== 4'b0101) begin failures++; $display("FAIL single_lsb: got %b want 0101", b); end
    checks++;
    if (lm !== 4'b0001) begin failures++; $display("FAIL single_last: got %b want 0001", lm); end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({sv0, sv1} !== 2'b00) begin failures++; $display("FAIL single_idle: got %b want 00", {sv0, sv1}); end
  endtask

  task automatic test_backpressure();
    logic [7:0] rp = 8'b1111_0001;
    logic [3:0] acc = 4'h0;
    int nv = 0;
    drive(1'b1, 4'b1100, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, rp[i], 1'b0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_bp cyc %0d: got %b want %b", i, obs(), exp_v());
      end
      if (sv0) nv++;
      if (sv0 && rp[i]) acc = {acc[2:0], s0};
      if (i >= 1 && i <= 3) begin
        checks++;
        if ({sv0, s0, sl0} !== 3'b110) begin
          failures++;
          $display("FAIL bp_stall cyc %0d: got %b want 110", i, {sv0, s0, sl0});
        end
      end
    end
    checks++;
    if (acc !== 4'b1100) begin failures++; $display("FAIL bp_seq: got %b want 1100", acc); end
    checks++;
    if (nv !== 7) begin failures++; $display("FAIL bp_len: got %0d want 7", nv); end
  endtask

  task automatic test_ignored();
    logic [3:0] acc = 4'h0;
    drive(1'b1, 4'b1001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 4'hF, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_ign cyc %0d: got %b want %b", i, obs(), exp_v());
      end
      if (i < 2) begin
        checks++;
        if (ir0 !== 1'b0) begin failures++; $display("FAIL ign_ready cyc %0d: got %b want 0", i, ir0); end
      end
      acc = {acc[2:0], s0};
    end
    checks++;
    if (acc !== 4'b1001) begin failures++; $display("FAIL ign_seq: got %b want 1001", acc); end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits = 8'h0, lm = 8'h0;
    int nv = 0;
    drive(1'b1, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(i == 3, 4'b0101, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_b2b cyc %0d: got %b want %b", i, obs(), exp_v());
      end
      bits = {bits[6:0], s0}; lm = {lm[6:0], sl0};
      if (sv0) nv++;
    end
    checks++;
    if (bits !== 8'b0011_0101) begin failures++; $display("FAIL b2b_seq: got %b want 00110101", bits); end
    checks++;
    if (lm !== 8'b0001_0001) begin failures++; $display("FAIL b2b_last: got %b want 00010001", lm); end
    checks++;
    if (nv !== 8) begin failures++; $display("FAIL b2b_len: got %0d want 8", nv); end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (sv0 !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b want 0", sv0); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] acc = 4'h0, lm = 4'h0;
    drive(1'b1, 4'hF, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    checks++;
    if ({ir0, ir1, sl0} !== 3'b000) begin
      failures++;
      $display("FAIL rmid_assert: got %b want 000", {ir0, ir1, sl0});
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({sv0, sl0, sv1, sl1} !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_abort: got %b want 0000", {sv0, sl0, sv1, sl1});
    end
    drive(1'b1, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_rmid cyc %0d: got %b want %b", i, obs(), exp_v());
      end
      acc = {acc[2:0], s0}; lm = {lm[2:0], sl0};
    end
    checks++;
    if (acc !== 4'b0110) begin failures++; $display("FAIL rmid_seq: got %b want 0110", acc); end
    checks++;
    if (lm !== 4'b0001) begin failures++; $display("FAIL rmid_last: got %b want 0001", lm); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      checks++;
      if (obs() !== exp_v()) begin
        failures++;
        $display("FAIL model_rand cyc %0d: got %b want %b", i, obs(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_4serializer.md
# bit_4serializer

Parallel-in, serial-out transmitter for 4-bit register words. It accepts a parallel word through a valid/ready load handshake and shifts it out one bit per accepted beat on a serial valid/ready link, flagging the final bit. It sits on the read side of the parallel-load register file and turns stored words into a serial stream for downstream single-bit consumers.

## Interface
- WIDTH, 4: word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 transmits D[WIDTH-1] first; 0 transmits D[0] first.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  parallel word valid.
- D  in  WIDTH  parallel word; sampled only on an accepted load.
- in_ready  out  1  serializer can accept a word this cycle.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout holds a valid bit.
- sout_last  out  1  current bit is the final bit of the word.
- sout_ready  in  1  downstream accepts the current bit.

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: word in flight.
- Shift register sreg is WIDTH bits. Beat counter cnt is clog2(WIDTH) bits.
- Load accept = load && in_ready at a rising edge:
  - sreg ← D and cnt ← 0.
  - State → SHIFT.
- Beat accept = sout_valid && sout_ready at a rising edge:
  - sreg shifts toward the output end and cnt increments.
  - Vacated bit positions fill with 0.
- Final beat:
  - The beat accepted with cnt == WIDTH-1 completes the word.
  - If no load is accepted on the same edge, state → IDLE.
  - If a load is accepted on the same edge, state stays SHIFT, sreg ← new D, cnt ← 0 (back-to-back, no bubble).
- in_ready = !rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1 && sout_ready)). in_ready is combinational from sout_ready.
- load asserted while in_ready is 0 is ignored. D is not captured and no error is raised.
- Outputs in SHIFT:
  - sout_valid = 1.
  - sout = sreg[WIDTH-1] when MSB_FIRST=1, otherwise sreg[0].
  - sout_last = (cnt == WIDTH-1).
- Outputs in IDLE: sout = 0, sout_valid = 0, sout_last = 0.
- Backpressure: while sout_valid && !sout_ready, sout, sout_last, sreg and cnt hold unchanged.
- Reset values:
  - state = IDLE, sreg = 0, cnt = 0.
  - sout = 0, sout_valid = 0, sout_last = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after release.
- Reset mid-word aborts the word. The next edge returns to IDLE and the partial word is discarded; no sout_last is emitted.
- rst has priority over load and sout_ready on the same edge.

## Timing
- Latency: load accepted at edge N → first bit valid in the cycle after N.
- With sout_ready held at 1:
  - Bit k appears in cycle N+1+k for k = 0..WIDTH-1.
  - sout_last is asserted in cycle N+WIDTH.
- Throughput: one word per WIDTH cycles when loads are back-to-back and sout_ready is 1.
- Each stall cycle (sout_ready = 0) adds exactly one cycle to the word.
- All outputs except in_ready are registered. in_ready has a combinational path from sout_ready and rst.

## Structure
- Shared include file serializer_defs.vh holds:
  - state encodings: IDLE = 1'b0, SHIFT = 1'b1.
  - the default WIDTH.
  - the clog2 width macro.
- One sub-module, shift_stage: a single sreg bit built from the existing DFF and mux2to1 cells.
  - Its mux selects among hold, load (D bit) and shift (neighbour bit).
  - It is instantiated WIDTH times with a generate loop.
- FSM, counter and handshake logic live in bit_4serializer.

## Test plan
- Reset: rst=1 for 2 cycles with load=1, D=1111 → sout_valid=0 and in_ready=0 throughout, nothing captured. After release: in_ready=1, sout=0.
- Single word: load with D=1010, sout_ready=1 → sout = 1,0,1,0 in four consecutive cycles, sout_last only on the 4th, then IDLE with sout_valid=0. Repeat with MSB_FIRST=0 → 0,1,0,1.
- Backpressure: load with D=1100, drop sout_ready for 3 cycles on the 2nd beat → sout holds 1 during the stall, sequence is 1,1,0,0, word completes 3 cycles late.
- Ignored load: while shifting D=1001, assert load with D=1111 on beats 1–2 → in_ready=0 on those beats, output stays 1,0,0,1.
- Back-to-back: load D=0011, then present D=0101 on its last beat → 8 contiguous valid cycles 0,0,1,1,0,1,0,1, sout_last on cycles 4 and 8.
- Reset mid-word: load D=1111, assert rst after 2 beats → sout_valid=0 at the next cycle, no sout_last. A following load of D=0110 transmits 0,1,1,0 cleanly.
